dvi_decoder: RTL and testbench
==============================

Name: dvi_decoder

Overview:
- Receive side of the single-channel 2-level DVI link.
- Takes raw 10-bit parallel words from the deserializer, which may be misaligned to symbol boundaries, and finds symbol alignment by bit-slip on control-symbol runs.
- Decodes the 8-symbol set back to pixel bit, DE, HS and VS, and checks symbol validity and disparity alternation.
- Sits between the deserializer and the pixel/timing consumer.

Parameters:
- LOCK_RUN, 16: consecutive control symbols at one offset needed to declare lock.
- SEARCH_WIN, 1024: words examined per offset before slipping to the next offset.
- ERR_LIMIT, 4: consecutive invalid symbols while locked that force loss of lock.

Ports:
- i_clk  in  1  word clock
- i_rstn  in  1  synchronous active-low reset
- i_word  in  10  raw deserialized word, bit 0 earliest on the wire
- o_pix  out  1  decoded pixel bit (1 = full intensity)
- o_de  out  1  data enable
- o_hs  out  1  hsync
- o_vs  out  1  vsync
- o_locked  out  1  symbol alignment achieved
- o_offset  out  4  current bit offset, 0..9
- o_err  out  1  one-cycle pulse per invalid symbol or disparity violation while locked

Behaviour:
- Clock and reset: one clock, i_clk. Reset is synchronous and active-low on i_rstn, sampled on the i_clk rising edge.
- Reset values: all outputs 0, internal state SEARCH, offset 0, all counters 0, expected-disparity = positive.
- Alignment window:
  - r_prev <= i_word every cycle.
  - window = {i_word, r_prev} (20 bits).
  - aligned symbol = window[offset+9 : offset].
- Latency: a word whose first bit is in i_word at cycle N produces registered outputs at cycle N+2. This holds for every offset.
- Symbol table (aligned, MSB first):
  - 1101010100 = CTRL, hs0 vs0
  - 0010101011 = CTRL, hs1 vs0
  - 0101010100 = CTRL, hs0 vs1
  - 1010101011 = CTRL, hs1 vs1
  - 1111111111 = pixel 0, positive disparity
  - 0100000000 = pixel 0, negative disparity
  - 0011111111 = pixel 1, positive disparity
  - 1000000000 = pixel 1, negative disparity
  - Any other value is invalid.
- State SEARCH:
  - o_locked = 0, o_de = 0, o_pix = 0, o_hs/o_vs = 0.
  - Run counter increments on each CTRL symbol and clears on any non-CTRL symbol.
  - Window counter increments every cycle.
  - Run counter reaching LOCK_RUN -> LOCKED. Window counter is not checked in that cycle.
  - Otherwise, window counter reaching SEARCH_WIN-1 -> offset increments (9 wraps to 0), and both counters clear.
  - After an offset change, the run counter is ignored for one cycle while r_prev refills.
- State LOCKED:
  - o_locked = 1.
  - CTRL symbol: o_de = 0, o_pix = 0, hs/vs from table; expected-disparity set to positive.
  - Pixel symbol:
    - o_de = 1, o_pix from table; hs/vs hold their last value.
    - If the symbol's disparity differs from expected -> o_err = 1.
    - Expected-disparity becomes the opposite of the received symbol's disparity, so tracking resyncs.
  - Invalid symbol: o_err = 1, o_de = 0, o_pix = 0, hs/vs hold.
  - Consecutive-invalid counter increments on each invalid symbol and clears on any valid symbol.
  - Counter reaching ERR_LIMIT -> SEARCH at the same offset, counters cleared, and o_locked = 0 from the next cycle.
- Simultaneous events: a disparity error and a CTRL symbol cannot coincide. An invalid symbol never updates expected-disparity.
- Reset asserted mid-operation: returns to the reset values on the next clock edge, regardless of state.
- All counters are sized with $clog2 of their parameter and saturate; they never wrap.

Optional Feature:
- Macro: DVI_DECODER_STATS_EN.
- When defined:
  - Adds output o_err_cnt (16 bits): saturating count of o_err pulses.
  - Adds output o_slip_cnt (8 bits): saturating count of offset increments.
  - Both clear on reset only.
- When undefined: neither port nor counter exists, and all other behaviour is identical.

Test Plan:
- Aligned stream of 20× CTRL0, then 8 pixel words 1111111111/0100000000 alternating -> o_locked rises after the 16th CTRL, output offset 0; then o_de = 1, o_pix = 0 for 8 cycles, o_err never pulses.
- Same stream bit-rotated by 3 bits across word boundaries, with LOCK_RUN=16 and SEARCH_WIN=64 -> offset steps 0,1,2,3 at 64-cycle intervals; lock at offset 3; decoded hs/vs/pix match the transmitted sequence with 2-cycle latency.
- Locked, send CTRL3 -> o_hs = 1, o_vs = 1, o_de = 0; then 0011111111 followed by 0011111111 -> second word gives o_err pulse, o_pix = 1 both cycles.
- Locked, send 4× 0000011111 -> o_err pulses 4 times; o_locked = 0 after the 4th; offset unchanged; outputs forced to 0.
- Locked mid-line, drive i_rstn = 0 for one edge -> all outputs 0, offset 0, state SEARCH on the next cycle.
- With DVI_DECODER_STATS_EN defined, repeat the slip and error scenarios -> o_slip_cnt = 3, o_err_cnt = 4.

Source files
------------

// File: rtl/dvi_decoder.sv
// -----------------------------------------------------------------------------
// dvi_decoder
//
// Receive side of the single-channel 2-level DVI link. Raw 10-bit words from
// the deserializer may be split across symbol boundaries. The block finds
// symbol alignment by bit-slip on runs of control symbols. Once locked, it
// decodes the 8-symbol set to pixel/DE/HS/VS and flags invalid symbols and
// broken disparity alternation.
//
// Parameters:
//   LOCK_RUN    consecutive control symbols at one offset needed to lock
//   SEARCH_WIN  words examined per offset before slipping to the next offset
//   ERR_LIMIT   consecutive invalid symbols while locked that drop lock
//
// Ports:
//   i_clk       word clock
//   i_rstn      synchronous active-low reset
//   i_word      raw deserialized word, bit 0 earliest on the wire
//   o_pix       decoded pixel bit (1 = full intensity)
//   o_de        data enable
//   o_hs        hsync
//   o_vs        vsync
//   o_locked    symbol alignment achieved (mirrors the FSM state)
//   o_offset    current bit offset, 0..9
//   o_err       one-cycle pulse per invalid symbol / disparity violation
//               while locked
//
// Optional build macro DVI_DECODER_STATS_EN adds:
//   o_err_cnt   saturating count of o_err pulses
//   o_slip_cnt  saturating count of offset increments
//
// Stream handshake: none. A new word is consumed on every i_clk edge and
// decoded outputs appear two cycles after the word carrying a symbol's first
// bit, at every offset.
// -----------------------------------------------------------------------------
module dvi_decoder #(
   parameter int LOCK_RUN   = 16,
   parameter int SEARCH_WIN = 1024,
   parameter int ERR_LIMIT  = 4
) (
   input  logic        i_clk,
   input  logic        i_rstn,
   input  logic [9:0]  i_word,
   output logic        o_pix,
   output logic        o_de,
   output logic        o_hs,
   output logic        o_vs,
   output logic        o_locked,
   output logic [3:0]  o_offset,
   output logic        o_err
`ifdef DVI_DECODER_STATS_EN
   ,
   output logic [15:0] o_err_cnt,
   output logic [7:0]  o_slip_cnt
`endif
);

   localparam int RUN_W = (LOCK_RUN   > 1) ? $clog2(LOCK_RUN)   : 1;
   localparam int WIN_W = (SEARCH_WIN > 1) ? $clog2(SEARCH_WIN) : 1;
   localparam int ERR_W = (ERR_LIMIT  > 1) ? $clog2(ERR_LIMIT)  : 1;

   localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(LOCK_RUN - 1);
   localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(SEARCH_WIN - 1);
   localparam logic [ERR_W-1:0] ERR_LAST = ERR_W'(ERR_LIMIT - 1);

   // Symbol set, aligned, MSB first.
   localparam logic [9:0] SYM_CTRL0 = 10'b1101010100;
   localparam logic [9:0] SYM_CTRL1 = 10'b0010101011;
   localparam logic [9:0] SYM_CTRL2 = 10'b0101010100;
   localparam logic [9:0] SYM_CTRL3 = 10'b1010101011;
   localparam logic [9:0] SYM_P0_POS = 10'b1111111111;
   localparam logic [9:0] SYM_P0_NEG = 10'b0100000000;
   localparam logic [9:0] SYM_P1_POS = 10'b0011111111;
   localparam logic [9:0] SYM_P1_NEG = 10'b1000000000;

   typedef enum logic {
      ST_SEARCH = 1'b0,
      ST_LOCKED = 1'b1
   } state_t;

   state_t           state;
   logic [9:0]       r_prev;
   logic [RUN_W-1:0] run_cnt;
   logic [WIN_W-1:0] win_cnt;
   logic [ERR_W-1:0] err_run;
   logic             exp_pos;   // next pixel symbol should carry positive disparity
   logic             r_skip;    // first cycle after a slip: run counter frozen

   // Two consecutive words form a 20-bit window; the symbol starts at the
   // current offset into the older word.
   logic [19:0] window;
   logic [9:0]  sym;

   assign window = {i_word, r_prev};
   assign sym    = 10'(window >> o_offset);

   logic is_ctrl;
   logic is_pix;
   logic pix_val;
   logic pix_pos;
   logic ctl_hs;
   logic ctl_vs;

   always_comb begin
      is_ctrl = 1'b0;
      is_pix  = 1'b0;
      pix_val = 1'b0;
      pix_pos = 1'b0;
      ctl_hs  = 1'b0;
      ctl_vs  = 1'b0;
      case (sym)
         SYM_CTRL0:  begin is_ctrl = 1'b1;                                   end
         SYM_CTRL1:  begin is_ctrl = 1'b1; ctl_hs = 1'b1;                    end
         SYM_CTRL2:  begin is_ctrl = 1'b1;                  ctl_vs = 1'b1;   end
         SYM_CTRL3:  begin is_ctrl = 1'b1; ctl_hs = 1'b1;   ctl_vs = 1'b1;   end
         SYM_P0_POS: begin is_pix  = 1'b1;                  pix_pos = 1'b1;  end
         SYM_P0_NEG: begin is_pix  = 1'b1;                                   end
         SYM_P1_POS: begin is_pix  = 1'b1; pix_val = 1'b1;  pix_pos = 1'b1;  end
         SYM_P1_NEG: begin is_pix  = 1'b1; pix_val = 1'b1;                   end
         default:    begin is_ctrl = 1'b0;                                   end
      endcase
   end

   // Cycle events. A lock takes priority over a slip in the same cycle, and
   // the refill cycle after a slip cannot lock.
   logic lock_evt;
   logic slip_evt;
   logic err_evt;
   logic lose_evt;

   always_comb begin
      lock_evt = (state == ST_SEARCH) && !r_skip && is_ctrl && (run_cnt == RUN_LAST);
      slip_evt = (state == ST_SEARCH) && !lock_evt && (win_cnt == WIN_LAST);
      err_evt  = (state == ST_LOCKED) && !is_ctrl && (!is_pix || (pix_pos != exp_pos));
      lose_evt = (state == ST_LOCKED) && !is_ctrl && !is_pix && (err_run == ERR_LAST);
   end

   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         state    <= ST_SEARCH;
         r_prev   <= '0;
         run_cnt  <= '0;
         win_cnt  <= '0;
         err_run  <= '0;
         exp_pos  <= 1'b1;
         r_skip   <= 1'b0;
         o_pix    <= 1'b0;
         o_de     <= 1'b0;
         o_hs     <= 1'b0;
         o_vs     <= 1'b0;
         o_locked <= 1'b0;
         o_offset <= 4'd0;
         o_err    <= 1'b0;
      end else begin
         r_prev <= i_word;
         r_skip <= slip_evt;
         o_err  <= err_evt;

         case (state)
            ST_SEARCH: begin
               o_pix    <= 1'b0;
               o_de     <= 1'b0;
               o_hs     <= 1'b0;
               o_vs     <= 1'b0;
               o_locked <= 1'b0;
               if (lock_evt) begin
                  state    <= ST_LOCKED;
                  o_locked <= 1'b1;
                  run_cnt  <= '0;
                  win_cnt  <= '0;
                  err_run  <= '0;
                  exp_pos  <= 1'b1;  // the locking symbol is a control symbol
               end else if (slip_evt) begin
                  o_offset <= (o_offset == 4'd9) ? 4'd0 : o_offset + 4'd1;
                  run_cnt  <= '0;
                  win_cnt  <= '0;
               end else begin
                  if (win_cnt != '1) win_cnt <= win_cnt + WIN_W'(1);
                  if (!r_skip) begin
                     if (!is_ctrl)             run_cnt <= '0;
                     else if (run_cnt != '1)   run_cnt <= run_cnt + RUN_W'(1);
                  end
               end
            end

            ST_LOCKED: begin
               o_locked <= 1'b1;
               if (is_ctrl) begin
                  o_de    <= 1'b0;
                  o_pix   <= 1'b0;
                  o_hs    <= ctl_hs;
                  o_vs    <= ctl_vs;
                  exp_pos <= 1'b1;
                  err_run <= '0;
               end else if (is_pix) begin
                  o_de    <= 1'b1;
                  o_pix   <= pix_val;
                  // Follow the received disparity so one bad symbol costs one
                  // error pulse, not a whole line of them.
                  exp_pos <= !pix_pos;
                  err_run <= '0;
               end else begin
                  o_de  <= 1'b0;
                  o_pix <= 1'b0;
                  if (lose_evt) begin
                     state    <= ST_SEARCH;
                     o_locked <= 1'b0;
                     err_run  <= '0;
                     run_cnt  <= '0;
                     win_cnt  <= '0;
                  end else if (err_run != '1) begin
                     err_run <= err_run + ERR_W'(1);
                  end
               end
            end

            default: state <= ST_SEARCH;
         endcase
      end
   end

`ifdef DVI_DECODER_STATS_EN
   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         o_err_cnt  <= '0;
         o_slip_cnt <= '0;
      end else begin
         if (err_evt && (o_err_cnt != '1))   o_err_cnt  <= o_err_cnt + 16'd1;
         if (slip_evt && (o_slip_cnt != '1)) o_slip_cnt <= o_slip_cnt + 8'd1;
      end
   end
`endif

endmodule

// File: tb/tb_dvi_decoder.sv
// -----------------------------------------------------------------------------
// tb_dvi_decoder
//
// Self-checking bench for dvi_decoder (LOCK_RUN=16, SEARCH_WIN=64,
// ERR_LIMIT=4). Each transmitted symbol pushes its expected registered output
// tuple {locked, de, pix, hs, vs, err, offset[3:0]} onto exp_q; the tuple is
// popped and compared when that symbol's outputs are due.
// Symbols can be sent aligned or rotated so that each symbol starts at bit 3
// of a word. Build with DVI_DECODER_STATS_EN to also check the counters.
// -----------------------------------------------------------------------------
module tb_dvi_decoder;

   localparam int LOCK_RUN   = 16;
   localparam int SEARCH_WIN = 64;
   localparam int ERR_LIMIT  = 4;

   localparam logic [9:0] C0  = 10'b1101010100;
   localparam logic [9:0] C1  = 10'b0010101011;
   localparam logic [9:0] C2  = 10'b0101010100;
   localparam logic [9:0] C3  = 10'b1010101011;
   localparam logic [9:0] P0P = 10'b1111111111;
   localparam logic [9:0] P0N = 10'b0100000000;
   localparam logic [9:0] P1P = 10'b0011111111;
   localparam logic [9:0] P1N = 10'b1000000000;
   localparam logic [9:0] BAD = 10'b0000011111;

   // ---------------- clock / reset / DUT ----------------
   logic       i_clk  = 1'b0;
   logic       i_rstn = 1'b0;
   logic [9:0] i_word = '0;
   logic       o_pix, o_de, o_hs, o_vs, o_locked, o_err;
   logic [3:0] o_offset;
`ifdef DVI_DECODER_STATS_EN
   logic [15:0] o_err_cnt;
   logic [7:0]  o_slip_cnt;
`endif

   always #5 i_clk = ~i_clk;

   dvi_decoder #(
      .LOCK_RUN   (LOCK_RUN),
      .SEARCH_WIN (SEARCH_WIN),
      .ERR_LIMIT  (ERR_LIMIT)
   ) dut (
      .i_clk      (i_clk),
      .i_rstn     (i_rstn),
      .i_word     (i_word),
      .o_pix      (o_pix),
      .o_de       (o_de),
      .o_hs       (o_hs),
      .o_vs       (o_vs),
      .o_locked   (o_locked),
      .o_offset   (o_offset),
      .o_err      (o_err)
`ifdef DVI_DECODER_STATS_EN
      ,
      .o_err_cnt  (o_err_cnt),
      .o_slip_cnt (o_slip_cnt)
`endif
   );

   // ---------------- scoreboard ----------------
   int         n_checks = 0;
   int         n_pass   = 0;
   logic [9:0] exp_q[$];
   string      tag_q[$];
   int         rot      = 0;     // bit position where each symbol starts
   logic [9:0] prev_sym = C0;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %b expected %b", tag, got, exp);
   endtask

   function automatic logic [9:0] ex(input logic l, input logic de, input logic pix,
                                     input logic hs, input logic vs, input logic err,
                                     input logic [3:0] off);
      return {l, de, pix, hs, vs, err, off};
   endfunction

   function automatic logic [9:0] obs();
      return {o_locked, o_de, o_pix, o_hs, o_vs, o_err, o_offset};
   endfunction

   // ---------------- driver tasks ----------------
   // Send one symbol. With rot=3 the word carries the symbol's first 7 bits
   // in [9:3] and the previous symbol's last 3 bits in [2:0].
   task automatic tx(input logic [9:0] sym, input logic [9:0] e, input string tag);
      logic [19:0] pair;
      logic [9:0]  e_front;
      string       t_front;
      pair     = {sym, prev_sym};
      i_word   = pair[(10 - rot) +: 10];
      prev_sym = sym;
      exp_q.push_back(e);
      tag_q.push_back(tag);
      @(posedge i_clk);
      #1;
      if (exp_q.size() >= 2) begin
         e_front = exp_q.pop_front();
         t_front = tag_q.pop_front();
         check(t_front, 16'(obs()), 16'(e_front));
      end
   endtask

   task automatic do_reset(input string tag);
      i_rstn = 1'b0;
      exp_q.delete();
      tag_q.delete();
      @(posedge i_clk);
      #1;
      check(tag, 16'(obs()), 16'd0);
`ifdef DVI_DECODER_STATS_EN
      check({tag, "_err_cnt"}, o_err_cnt, 16'd0);
      check({tag, "_slip_cnt"}, 16'(o_slip_cnt), 16'd0);
`endif
      i_rstn   = 1'b1;
      prev_sym = C0;
   endtask

   // ---------------- stimulus ----------------
   logic [9:0] b_sym[9] = '{C1, P1P, P1N, C2, P0P, P0N, C3, P1P, C0};
   logic [3:0] b_exp[9] = '{4'b0010, 4'b1110, 4'b1110, 4'b0001, 4'b1001,
                            4'b1001, 4'b0011, 4'b1111, 4'b0000};  // {de,pix,hs,vs}

   initial begin
      rot = 0;
      do_reset("reset_init");

      // Aligned: lock on the 16th CTRL0, then 8 alternating pixel-0 symbols.
      for (int i = 0; i < 20; i++)
         tx(C0, ex(i >= 15, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0), $sformatf("a_ctrl%0d", i));
      for (int i = 0; i < 8; i++)
         tx((i % 2) ? P0N : P0P, ex(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0),
            $sformatf("a_pix%0d", i));

      // CTRL3, repeated positive pixel-1 (disparity error), invalid with
      // hs/vs hold, and a pixel after the invalid that still matches.
      tx(C3,  ex(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0), "c_ctrl3");
      tx(P1P, ex(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0), "c_p1_first");
      tx(P1P, ex(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'd0), "c_p1_disp_err");
      tx(BAD, ex(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'd0), "c_bad_hold");
      tx(P1N, ex(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0), "c_disp_after_bad");
      tx(C0,  ex(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0), "c_ctrl0");

      // Four invalid symbols drop lock; a fifth, while searching, is silent.
      for (int k = 0; k < 4; k++)
         tx(BAD, ex(k < 3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0), $sformatf("d_bad%0d", k));
      tx(BAD, ex(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0), "d_bad_search");

      // Relock at the same offset.
      for (int i = 0; i < 20; i++)
         tx(C0, ex(i >= 15, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0), $sformatf("r_ctrl%0d", i));
`ifdef DVI_DECODER_STATS_EN
      check("stats_err_cnt", o_err_cnt, 16'd6);
`endif

      do_reset("reset_pre_rot");

      // Rotated by 3: slips at edges 64/128/192, lock 17 edges after the last.
      rot = 3;
      for (int i = 0; i < 250; i++) begin
         int off;
         off = (i + 2) / SEARCH_WIN;
         if (off > 3) off = 3;
         tx(C0, ex(i >= 207, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'(off)),
            $sformatf("b_ctrl%0d", i));
      end
      for (int k = 0; k < 9; k++)
         tx(b_sym[k], ex(1'b1, b_exp[k][3], b_exp[k][2], b_exp[k][1], b_exp[k][0], 1'b0, 4'd3),
            $sformatf("b_tail%0d", k));
      tx(P0P, ex(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd3), "b_midline");
      tx(P0N, ex(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd3), "b_midline2");
`ifdef DVI_DECODER_STATS_EN
      check("stats_slip_cnt", 16'(o_slip_cnt), 16'd3);
      check("stats_err_cnt_rot", o_err_cnt, 16'd0);
`endif

      // Reset while locked mid-line at offset 3.
      do_reset("reset_midline");
      rot = 0;
      for (int i = 0; i < 5; i++)
         tx(C0, ex(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0), $sformatf("e_search%0d", i));
      tx(C0, ex(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0), "e_flush");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish, got %0d checks expected completion", n_checks);
      $fatal(1);
   end

endmodule
